// File: rtl/gn_reset_pkg.sv
// Shared types and helpers for the reset monitor: FSM state encoding and
// saturating statistics counters.
package gn_reset_pkg;

  localparam int unsigned C_STAT_W = 8;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_LOW,
    ST_HIGH
  } rst_mon_state_t;

  function automatic logic [C_STAT_W-1:0] sat_inc(input logic [C_STAT_W-1:0] v);
    return (v == '1) ? v : v + C_STAT_W'(1);
  endfunction

endpackage

// File: rtl/gn_sync_ff.sv
// Multi-flop synchroniser bringing an asynchronous level into clk_i; clears to 0 on reset.
module gn_sync_ff #(
  parameter int unsigned P_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [P_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[P_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[P_STAGES-1];

endmodule

// File: rtl/gn_reset_monitor.sv
// Reset monitor: synchronises and debounces an active-low reset, pulses on release,
// measures low durations and keeps assertion/glitch/short-pulse statistics.
module gn_reset_monitor
  import gn_reset_pkg::*;
#(
  parameter int unsigned P_SYNC_STAGES = 2,
  parameter int unsigned P_FILT_CYC    = 2,
  parameter int unsigned P_MIN_LOW_CYC = 8,
  parameter int unsigned P_CNT_W       = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                mon_reset_n_i,
  input  logic                clr_i,
  output logic                rst_active_o,
  output logic                rst_rel_o,
  output logic [P_CNT_W-1:0]  low_cycles_o,
  output logic [C_STAT_W-1:0] assert_cnt_o,
  output logic [C_STAT_W-1:0] glitch_cnt_o,
  output logic                short_err_o
);

  localparam int unsigned FcntW = $clog2(P_FILT_CYC + 1);

  logic s;

  gn_sync_ff #(
    .P_STAGES(P_SYNC_STAGES)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(reset_i),
    .d_i  (mon_reset_n_i),
    .q_o  (s)
  );

  logic               filt_q, filt_d;
  logic [FcntW-1:0]   fcnt_q, fcnt_d;
  logic               glitch;
  logic               rise, fall;
  logic [P_CNT_W-1:0] run_q, run_inc;

  rst_mon_state_t     state_q;
  logic               rst_active_q, rst_rel_q, short_err_q;
  logic [P_CNT_W-1:0] low_cycles_q;
  logic [C_STAT_W-1:0] assert_cnt_q, glitch_cnt_q;

  // A new level is accepted only after holding P_FILT_CYC cycles; an early return is a glitch.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    glitch = 1'b0;
    if (s != filt_q) begin
      if (32'(fcnt_q) + 32'd1 >= P_FILT_CYC) begin
        filt_d = s;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + FcntW'(1);
      end
    end else if (fcnt_q != '0) begin
      fcnt_d = '0;
      glitch = 1'b1;
    end
  end

  assign rise    = filt_d & ~filt_q;
  assign fall    = ~filt_d & filt_q;
  assign run_inc = (run_q == '1) ? run_q : run_q + P_CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      filt_q       <= 1'b0;
      fcnt_q       <= '0;
      state_q      <= ST_INIT;
      run_q        <= '0;
      rst_active_q <= 1'b1;
      rst_rel_q    <= 1'b0;
      low_cycles_q <= '0;
      assert_cnt_q <= '0;
      glitch_cnt_q <= '0;
      short_err_q  <= 1'b0;
    end else begin
      filt_q       <= filt_d;
      fcnt_q       <= fcnt_d;
      rst_active_q <= ~filt_d;
      rst_rel_q    <= 1'b0;

      // Clear first so that a same-cycle update event below overrides it.
      if (clr_i) begin
        low_cycles_q <= '0;
        assert_cnt_q <= '0;
        glitch_cnt_q <= '0;
        short_err_q  <= 1'b0;
      end
      if (glitch) begin
        glitch_cnt_q <= sat_inc(clr_i ? C_STAT_W'(0) : glitch_cnt_q);
      end

      unique case (state_q)
        ST_INIT, ST_LOW: begin
          if (rise) begin
            state_q      <= ST_HIGH;
            rst_rel_q    <= 1'b1;
            low_cycles_q <= run_q;
            if (state_q == ST_LOW && run_q < P_CNT_W'(P_MIN_LOW_CYC)) begin
              short_err_q <= 1'b1;
            end
          end else begin
            run_q <= run_inc;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state_q      <= ST_LOW;
            run_q        <= P_CNT_W'(1);
            assert_cnt_q <= sat_inc(clr_i ? C_STAT_W'(0) : assert_cnt_q);
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign rst_active_o = rst_active_q;
  assign rst_rel_o    = rst_rel_q;
  assign low_cycles_o = low_cycles_q;
  assign assert_cnt_o = assert_cnt_q;
  assign glitch_cnt_o = glitch_cnt_q;
  assign short_err_o  = short_err_q;

endmodule
